// File: rtl/boot_pkg.sv
// Shared state encoding and default sizing for the instruction-memory boot sequencer.
// Pure declarations; no logic, no latency, no flow control.
package boot_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RST_HOLD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    ERROR
  } boot_state_e;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Streams a program into instruction memory and keeps the core in reset until it has landed.
// Each accepted word is written one cycle later; ld_ready is high only while loading, so the host simply stalls otherwise.
module imem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RST_HOLD = DEF_RST_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic [ADDR_W:0]   words_loaded,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int              HOLD_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};

  boot_state_e       state;
  boot_state_e       state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              core_reset_q;
  logic              xfer;

  assign ld_ready   = (state == LOAD);
  assign xfer       = ld_valid & ld_ready;
  // The core must also see the block reset, even before the register settles.
  assign core_reset = core_reset_q | ~reset;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (load_start) state_nxt = LOAD;
      LOAD: begin
        if (xfer) begin
          if (ld_last)    state_nxt = HOLD;
          else if (&addr) state_nxt = ERROR;
        end
      end
      HOLD:  if (hold_cnt == HOLD_W'(RST_HOLD)) state_nxt = RUN;
      RUN:   if (load_start) state_nxt = LOAD;
      ERROR: if (load_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      addr         <= '0;
      hold_cnt     <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      core_reset_q <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      imem_we      <= xfer;
      core_reset_q <= (state_nxt != RUN);
      busy         <= (state_nxt == LOAD) || (state_nxt == HOLD);
      done         <= (state_nxt == RUN);
      err          <= (state_nxt == ERROR);

      if (xfer) begin
        imem_waddr <= addr;
        imem_wdata <= ld_data;
        addr       <= addr + 1'b1;
        if (words_loaded != DEPTH) words_loaded <= words_loaded + 1'b1;
      end

      // Entering LOAD from any other state starts a fresh program at word 0.
      if ((state != LOAD) && (state_nxt == LOAD)) begin
        addr         <= '0;
        words_loaded <= '0;
      end

      // Counter is zero on the first HOLD cycle, so RUN follows RST_HOLD+1 cycles after the last write is accepted.
      if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      else               hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized scoreboard bench for imem_boot_ctrl, plus a small-depth instance for the overflow path.
module tb_imem_boot_ctrl;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int RST_HOLD = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  localparam int M_IDLE = 0, M_LOAD = 1, M_HOLD = 2, M_RUN = 3, M_ERR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b0;
  logic              load_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_reset;
  logic [ADDR_W:0]   words_loaded;
  logic              busy, done, err;

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_reset(core_reset),
    .words_loaded(words_loaded), .busy(busy), .done(done), .err(err)
  );

  logic        r2 = 1'b0, ls2 = 1'b0, v2 = 1'b0, last2 = 1'b0;
  logic [31:0] d2 = '0;
  logic        rdy2, we2, cr2, busy2, done2, err2;
  logic [1:0]  waddr2;
  logic [31:0] wdata2;
  logic [2:0]  wl2;

  imem_boot_ctrl #(.ADDR_W(2), .DATA_W(32), .RST_HOLD(RST_HOLD)) dut2 (
    .clk(clk), .reset(r2), .load_start(ls2), .ld_valid(v2), .ld_ready(rdy2),
    .ld_data(d2), .ld_last(last2), .imem_we(we2), .imem_waddr(waddr2),
    .imem_wdata(wdata2), .core_reset(cr2), .words_loaded(wl2), .busy(busy2),
    .done(done2), .err(err2)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: what the block should be doing after each clock edge.
  int          m_mode  = M_IDLE;
  int          m_addr  = 0;
  int          m_cnt   = 0;
  int          m_hold  = 0;
  bit          m_wr    = 1'b0;
  bit          m_fresh = 1'b1;
  bit          mon_en  = 1'b0;
  logic [39:0] exp_q[$];

  logic [31:0] fixed_prog [5] = '{32'h002082B3, 32'h40310333, 32'h00512023,
                                  32'h00012303, 32'hFE208EE3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_wr = 1'b0;
    if (!reset) begin
      m_mode  = M_IDLE;
      m_cnt   = 0;
      m_fresh = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE, M_RUN, M_ERR: begin
          if (load_start) begin
            m_mode = M_LOAD;
            m_addr = 0;
            m_cnt  = 0;
          end
        end
        M_LOAD: begin
          if (ld_valid) begin
            exp_q.push_back({8'(m_addr), ld_data});
            m_wr    = 1'b1;
            m_fresh = 1'b0;
            if (m_cnt < DEPTH) m_cnt++;
            if (ld_last)                 begin m_mode = M_HOLD; m_hold = RST_HOLD + 1; end
            else if (m_addr == DEPTH-1)  m_mode = M_ERR;
            m_addr++;
          end
        end
        M_HOLD: begin
          m_hold--;
          if (m_hold == 0) m_mode = M_RUN;
        end
        default: m_mode = M_IDLE;
      endcase
    end
    #1;
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    if (mon_en) begin
      chk("ld_ready",     64'(ld_ready),     64'(m_mode == M_LOAD));
      chk("core_reset",   64'(core_reset),   64'(m_mode != M_RUN));
      chk("done",         64'(done),         64'(m_mode == M_RUN));
      chk("err",          64'(err),          64'(m_mode == M_ERR));
      chk("busy",         64'(busy),         64'(m_mode == M_LOAD || m_mode == M_HOLD));
      chk("words_loaded", 64'(words_loaded), 64'(m_cnt));
      chk("imem_we",      64'(imem_we),      64'(m_wr));
      if (m_fresh) begin
        chk("waddr_reset", 64'(imem_waddr), 64'd0);
        chk("wdata_reset", 64'(imem_wdata), 64'd0);
      end
      if (imem_we && m_wr) begin
        if (exp_q.size() == 0) chk("write_queue_empty", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("imem_waddr", 64'(imem_waddr), 64'(e[39:32]));
          chk("imem_wdata", 64'(imem_wdata), 64'(e[31:0]));
        end
      end
    end
  end

  task automatic idle_cycles(input int k);
    for (int j = 0; j < k; j++) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = $urandom;
      ld_last  = 1'($urandom_range(0, 1));
      cyc();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random valid.
  task automatic load_prog(input int n, input int mode, input int abort_at, input bit use_fixed);
    int i = 0;
    int k = 0;
    bit v;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    while (i < n) begin
      if (i == abort_at) begin
        reset = 1'b0; load_start = 1'b1; ld_valid = 1'b1;
        cyc();
        load_start = 1'b0;
        cyc();
        reset = 1'b1; ld_valid = 1'b0;
        return;
      end
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      ld_valid   = v;
      ld_data    = (v && use_fixed) ? fixed_prog[i] : $urandom;
      ld_last    = v ? (i == n - 1) : 1'($urandom_range(0, 1));
      load_start = (mode == 2) && v && (i < n - 1) && ($urandom_range(0, 5) == 0);
      cyc();
      if (v) i++;
      k++;
    end
    ld_valid = 1'b0; ld_last = 1'b0; load_start = 1'b0;
  endtask

  initial begin
    cyc();
    mon_en = 1'b1;
    cyc();
    reset = 1'b1;
    idle_cycles(3);

    load_prog(5, 0, -1, 1'b1);
    idle_cycles(RST_HOLD + 3);

    load_prog(6, 1, -1, 1'b0);
    idle_cycles(RST_HOLD + 3);

    load_prog(2, 0, -1, 1'b0);
    idle_cycles(RST_HOLD + 3);

    load_prog(5, 0, 3, 1'b0);
    idle_cycles(2);

    for (int p = 0; p < 15; p++) begin
      load_prog($urandom_range(1, 12), $urandom_range(0, 2), -1, 1'b0);
      idle_cycles(RST_HOLD + 1 + $urandom_range(2, 4));
    end

    r2 = 1'b1;
    cyc();
    ls2 = 1'b1;
    cyc();
    ls2 = 1'b0;
    chk("ovf_ready", 64'(rdy2), 64'd1);
    for (int i = 0; i < 4; i++) begin
      v2 = 1'b1; d2 = $urandom; last2 = 1'b0;
      cyc();
      chk("ovf_we",    64'(we2),    64'd1);
      chk("ovf_waddr", 64'(waddr2), 64'(i));
      chk("ovf_wdata", 64'(wdata2), 64'(d2));
    end
    v2 = 1'b0;
    cyc();
    chk("ovf_err",        64'(err2),  64'd1);
    chk("ovf_core_reset", 64'(cr2),   64'd1);
    chk("ovf_done",       64'(done2), 64'd0);
    chk("ovf_words",      64'(wl2),   64'd4);
    chk("ovf_ready_off",  64'(rdy2),  64'd0);
    chk("ovf_we_off",     64'(we2),   64'd0);
    ls2 = 1'b1;
    cyc();
    ls2 = 1'b0;
    chk("ovf_err_clear",   64'(err2), 64'd0);
    chk("ovf_reload_rdy",  64'(rdy2), 64'd1);
    chk("ovf_words_clear", 64'(wl2),  64'd0);

    idle_cycles(2);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
